// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions for the RX and TX sides.
// Frame constants, receiver states and bit-period helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // Clocks per bit, integer divide.
  function automatic int unsigned calc_cycle(
    input int unsigned clk_fre,
    input int unsigned baud
  );
    return (clk_fre * 32'd1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin 2-FF synchroniser plus an edge-detect flop.
// Ports: clk, rst_n, rx_pin in; rx_sync (synced line), rx_fall (1->0) out.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin,
  output logic rx_sync,
  output logic rx_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to idle-high so a quiet line shows no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_bit_rx_module.sv
// 8N1 UART receiver: start validation, mid-bit sampling, stop check.
// Ports: clk, rst_n, rx_pin, rx_data_ready in; rx_data, rx_data_valid, rx_frame_err, rx_overrun out.
module uart_bit_rx_module
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [15:0] HALF_M1 = 16'(CYCLE / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CYCLE - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_sync;
  logic rx_fall;

  rx_state_e   state_q;
  logic [15:0] cycle_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .rx_sync(rx_sync),
    .rx_fall(rx_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
      if (valid_q && rx_data_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          cycle_cnt_q <= '0;
          if (rx_fall) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cycle_cnt_q == HALF_M1) begin
            cycle_cnt_q <= '0;
            state_q     <= rx_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cycle_cnt_q == FULL_M1) begin
            cycle_cnt_q        <= '0;
            shift_q[bit_cnt_q] <= rx_sync;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (cycle_cnt_q == FULL_M1) begin
            cycle_cnt_q <= '0;
            if (rx_sync) begin
              // A new byte wins over a same-cycle accept;
              // only an unaccepted old byte is an overrun.
              data_q  <= shift_q;
              valid_q <= 1'b1;
              ovr_q   <= valid_q & ~rx_data_ready;
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          cycle_cnt_q <= '0;
          if (rx_sync) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          cycle_cnt_q <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;

endmodule
